// File: rtl/mips_trace_pkg.sv
// Shared types for the MIPS commit-trace collector: event kinds and the
// packed queue entry {kind, pc, addr, data} with its pack/unpack helpers.
package mips_trace_pkg;

    localparam logic TRC_KIND_GRF = 1'b0;
    localparam logic TRC_KIND_DM  = 1'b1;
    localparam int   TRC_ENTRY_W  = 97;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trc_entry_t;

    function automatic logic [TRC_ENTRY_W-1:0] trc_pack(input trc_entry_t e);
        return {e.kind, e.pc, e.addr, e.data};
    endfunction

    function automatic trc_entry_t trc_unpack(input logic [TRC_ENTRY_W-1:0] v);
        trc_entry_t e;
        e.kind = v[96];
        e.pc   = v[95:64];
        e.addr = v[63:32];
        e.data = v[31:0];
        return e;
    endfunction

endpackage

// File: rtl/mips_trace_collector_if.sv
// Valid/ready trace stream carrying one committed write event per beat.
interface mips_trace_collector_if;

    logic        trc_valid;
    logic        trc_ready;
    logic        trc_kind;
    logic [31:0] trc_pc;
    logic [31:0] trc_addr;
    logic [31:0] trc_data;

    modport master (
        output trc_valid, trc_kind, trc_pc, trc_addr, trc_data,
        input  trc_ready
    );

    modport slave (
        input  trc_valid, trc_kind, trc_pc, trc_addr, trc_data,
        output trc_ready
    );

endinterface

// File: rtl/mips_trace_collector_trace_fifo.sv
// Register-based FIFO with two in-order push ports and one pop port; the
// head entry is read combinationally so a push is visible right after its edge.
module trace_fifo
    import mips_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push0,
    input  logic [TRC_ENTRY_W-1:0] push0_data,
    input  logic                   push1,
    input  logic [TRC_ENTRY_W-1:0] push1_data,
    input  logic                   pop,
    output logic [TRC_ENTRY_W-1:0] rd_data,
    output logic [CNT_W-1:0]       count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [TRC_ENTRY_W-1:0] mem_q [DEPTH];
    logic [TRC_ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [1:0]             n_push;
    logic                   do_pop;

    // push1 is only honoured together with push0, which keeps the two
    // pushes of one cycle adjacent and in order.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        n_push   = 2'd0;
        do_pop   = pop && (count_q != '0);
        if (push0) begin
            mem_d[wr_ptr_q] = push0_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            n_push          = 2'd1;
            if (push1) begin
                mem_d[wr_ptr_q + PTR_W'(1)] = push1_data;
                wr_ptr_d                    = wr_ptr_q + PTR_W'(2);
                n_push                      = 2'd2;
            end
        end
        rd_ptr_d = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(n_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);

endmodule

// File: rtl/mips_trace_collector.sv
// Taps GRF writes and DM stores of the MIPS core, queues them and streams them out.
// Optional TRACE_DROP_CNT_EN adds a saturating 16-bit count of dropped events.
module mips_trace_collector
    import mips_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             pc,
    input  logic                    grf_we,
    input  logic [4:0]              grf_addr,
    input  logic [31:0]             grf_wdata,
    input  logic                    dm_we,
    input  logic [31:0]             dm_addr,
    input  logic [31:0]             dm_wdata,
    mips_trace_collector_if.master  trc,
    output logic                    overflow
`ifdef TRACE_DROP_CNT_EN
    ,
    output logic [15:0]             drop_cnt
`endif
);

    logic                   grf_evt, dm_evt, pop;
    logic [1:0]             n_evt, n_acc, n_drop;
    logic [CNT_W-1:0]       free_slots, fifo_count;
    logic                   fifo_full, fifo_empty;
    logic                   push0, push1;
    logic [TRC_ENTRY_W-1:0] push0_data, push1_data, head_raw;
    trc_entry_t             grf_entry, dm_entry, head;
    logic                   overflow_q, overflow_d;

    always_comb begin
        grf_evt    = grf_we && (grf_addr != 5'd0);
        dm_evt     = dm_we;
        grf_entry  = '{kind: TRC_KIND_GRF, pc: pc, addr: {27'b0, grf_addr}, data: grf_wdata};
        dm_entry   = '{kind: TRC_KIND_DM, pc: pc, addr: dm_addr, data: dm_wdata};
        n_evt      = {1'b0, grf_evt} + {1'b0, dm_evt};
        pop        = !fifo_empty && trc.trc_ready;
        // A slot being popped this edge is reusable by a push on the same edge.
        free_slots = fifo_full ? CNT_W'(pop) : CNT_W'(DEPTH) - fifo_count + CNT_W'(pop);
        n_acc      = (free_slots >= CNT_W'(n_evt)) ? n_evt : free_slots[1:0];
        n_drop     = n_evt - n_acc;
        // GRF always goes first, so a lone accepted slot keeps the GRF event.
        push0      = (n_acc != 2'd0);
        push1      = (n_acc == 2'd2);
        push0_data = trc_pack(grf_evt ? grf_entry : dm_entry);
        push1_data = trc_pack(dm_entry);
        overflow_d = overflow_q || (n_drop != 2'd0);
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push0      (push0),
        .push0_data (push0_data),
        .push1      (push1),
        .push1_data (push1_data),
        .pop        (pop),
        .rd_data    (head_raw),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Outputs read as zero whenever nothing is queued.
    always_comb begin
        head          = trc_unpack(head_raw);
        trc.trc_valid = !fifo_empty;
        trc.trc_kind  = fifo_empty ? 1'b0  : head.kind;
        trc.trc_pc    = fifo_empty ? 32'd0 : head.pc;
        trc.trc_addr  = fifo_empty ? 32'd0 : head.addr;
        trc.trc_data  = fifo_empty ? 32'd0 : head.data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

`ifdef TRACE_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] drop_sum;

    always_comb begin
        drop_sum   = {1'b0, drop_cnt_q} + 17'(n_drop);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mips_trace_collector.sv
// Bench for mips_trace_collector: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_mips_trace_collector;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pc = '0;
    logic        grf_we = 1'b0;
    logic [4:0]  grf_addr = '0;
    logic [31:0] grf_wdata = '0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        overflow;
`ifdef TRACE_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    mips_trace_collector_if trc_if();

    mips_trace_collector #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset_n),
        .pc        (pc),
        .grf_we    (grf_we),
        .grf_addr  (grf_addr),
        .grf_wdata (grf_wdata),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .trc       (trc_if),
        .overflow  (overflow)
`ifdef TRACE_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        gw;
        logic [4:0]  ga;
        logic [31:0] gd;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dd;
        logic [31:0] p;
        int          exp_n;
        logic        exp_kind;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic [31:0] exp_addr1;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic gw, input logic [4:0] ga, input logic [31:0] gd,
                         input logic dw, input logic [31:0] da, input logic [31:0] dd,
                         input logic [31:0] p);
        grf_we = gw; grf_addr = ga; grf_wdata = gd;
        dm_we = dw; dm_addr = da; dm_wdata = dd; pc = p;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        idle();
        trc_if.trc_ready = 1'b0;
        #2 reset_n = 1'b0;
        tick();
        tick();
        #2 reset_n = 1'b1;
        tick();
    endtask

    function automatic logic [96:0] head_now();
        return {trc_if.trc_kind, trc_if.trc_pc, trc_if.trc_addr, trc_if.trc_data};
    endfunction

    // reference model state for random traffic
    logic [96:0] model_q [$];
    logic        m_ovf;
    int          m_drops;

    initial begin
        int n;
        logic [31:0] second_addr;
        logic [31:0] exp_d [$];
        logic gw, dw, rdy;
        logic [4:0] ga;
        logic [31:0] gd, da, dd, p;
        logic [96:0] exp_head;

        vecs[0] = '{1'b1, 5'd5,  32'h1234, 1'b0, 32'h0,    32'h0,    32'h3000, 1, 1'b0, 32'd5,    32'h1234,  32'h0};
        vecs[1] = '{1'b1, 5'd0,  32'hDEAD, 1'b0, 32'h0,    32'h0,    32'h3004, 0, 1'b0, 32'd0,    32'h0,     32'h0};
        vecs[2] = '{1'b1, 5'd8,  32'h1,    1'b1, 32'h10,   32'h2,    32'h3008, 2, 1'b0, 32'd8,    32'h1,     32'h10};
        vecs[3] = '{1'b0, 5'd3,  32'h77,   1'b1, 32'h2000, 32'hBEEF, 32'h300C, 1, 1'b1, 32'h2000, 32'hBEEF,  32'h0};
        vecs[4] = '{1'b1, 5'd0,  32'h55,   1'b1, 32'h44,   32'h66,   32'h3010, 1, 1'b1, 32'h44,   32'h66,    32'h0};
        vecs[5] = '{1'b0, 5'd9,  32'h99,   1'b0, 32'h48,   32'h11,   32'h3014, 0, 1'b0, 32'd0,    32'h0,     32'h0};
        vecs[6] = '{1'b1, 5'd31, 32'hCAFE, 1'b0, 32'h0,    32'h0,    32'h3018, 1, 1'b0, 32'd31,   32'hCAFE,  32'h0};

        // 1: reset state held with no events
        do_reset();
        for (int i = 0; i < 10; i++) begin
            chk("idle_valid", 128'(trc_if.trc_valid), 128'd0);
            chk("idle_ovf", 128'(overflow), 128'd0);
            chk("idle_fields", 128'(head_now()), 128'd0);
            tick();
        end

        // 2..4 and extra patterns: one cycle of events into an empty FIFO
        for (int v = 0; v < 7; v++) begin
            trc_if.trc_ready = 1'b0;
            drive(vecs[v].gw, vecs[v].ga, vecs[v].gd, vecs[v].dw, vecs[v].da, vecs[v].dd, vecs[v].p);
            tick();
            idle();
            chk($sformatf("vec%0d_valid", v), 128'(trc_if.trc_valid), 128'(vecs[v].exp_n != 0));
            if (vecs[v].exp_n != 0) begin
                chk($sformatf("vec%0d_head", v), 128'(head_now()),
                    128'({vecs[v].exp_kind, vecs[v].p, vecs[v].exp_addr, vecs[v].exp_data}));
            end
            trc_if.trc_ready = 1'b1;
            n = 0;
            second_addr = '0;
            for (int k = 0; k < DEPTH + 2; k++) begin
                if (trc_if.trc_valid) begin
                    if (n == 1) second_addr = trc_if.trc_addr;
                    n++;
                end
                tick();
            end
            chk($sformatf("vec%0d_count", v), 128'(n), 128'(vecs[v].exp_n));
            if (vecs[v].exp_n == 2) begin
                chk($sformatf("vec%0d_second_addr", v), 128'(second_addr), 128'(vecs[v].exp_addr1));
            end
            trc_if.trc_ready = 1'b0;
            chk($sformatf("vec%0d_ovf", v), 128'(overflow), 128'd0);
        end

        // 5: DEPTH+1 pushes with no consumer; last one dropped
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            drive(1'b1, 5'(i % 31 + 1), 32'hA000 + 32'(i), 1'b0, 32'd0, 32'd0, 32'h400 + 32'(4 * i));
            tick();
        end
        idle();
        chk("ovf_set", 128'(overflow), 128'd1);
`ifdef TRACE_DROP_CNT_EN
        chk("drop_cnt_one", 128'(drop_cnt), 128'd1);
`endif
        trc_if.trc_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_valid", 128'(trc_if.trc_valid), 128'd1);
            chk("drain_data", 128'(trc_if.trc_data), 128'(32'hA000 + 32'(i)));
            tick();
        end
        chk("drain_empty", 128'(trc_if.trc_valid), 128'd0);
        chk("ovf_sticky", 128'(overflow), 128'd1);

        // 6: full FIFO, one push and one pop per cycle, then async reset
        do_reset();
        exp_d.delete();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 5'(i + 1), 32'hB000 + 32'(i), 1'b0, 32'd0, 32'd0, 32'h500);
            exp_d.push_back(32'hB000 + 32'(i));
            tick();
        end
        trc_if.trc_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1, 32'h800 + 32'(i), 32'hC000 + 32'(i), 32'h600);
            void'(exp_d.pop_front());
            exp_d.push_back(32'hC000 + 32'(i));
            tick();
            chk("stream_valid", 128'(trc_if.trc_valid), 128'd1);
            chk("stream_data", 128'(trc_if.trc_data), 128'(exp_d[0]));
            chk("stream_ovf", 128'(overflow), 128'd0);
        end
        trc_if.trc_ready = 1'b0;
        drive(1'b1, 5'd7, 32'hD00D, 1'b0, 32'd0, 32'd0, 32'h700);
        tick();
        idle();
        chk("still_full_ovf", 128'(overflow), 128'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 128'(trc_if.trc_valid), 128'd0);
        chk("async_rst_fields", 128'(head_now()), 128'd0);
        chk("async_rst_ovf", 128'(overflow), 128'd0);
        tick();
        #2 reset_n = 1'b1;
        tick();
        chk("post_rst_valid", 128'(trc_if.trc_valid), 128'd0);

        // randomized traffic against the queue model
        do_reset();
        model_q.delete();
        m_ovf = 1'b0;
        m_drops = 0;
        for (int c = 0; c < 3000; c++) begin
            exp_head = (model_q.size() != 0) ? model_q[0] : 97'd0;
            chk("rnd_valid", 128'(trc_if.trc_valid), 128'(model_q.size() != 0));
            chk("rnd_head", 128'(head_now()), 128'(exp_head));
            chk("rnd_ovf", 128'(overflow), 128'(m_ovf));
`ifdef TRACE_DROP_CNT_EN
            chk("rnd_drop_cnt", 128'(drop_cnt), 128'(m_drops));
`endif
            gw = ($urandom_range(0, 99) < 60);
            ga = 5'($urandom_range(0, 31));
            gd = $urandom();
            dw = ($urandom_range(0, 99) < 40);
            da = $urandom();
            dd = $urandom();
            p  = $urandom();
            rdy = ((c / 200) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            drive(gw, ga, gd, dw, da, dd, p);
            trc_if.trc_ready = rdy;
            if (model_q.size() != 0 && rdy) void'(model_q.pop_front());
            if (gw && ga != 5'd0) begin
                if (model_q.size() < DEPTH) model_q.push_back({1'b0, p, 27'd0, ga, gd});
                else begin m_ovf = 1'b1; m_drops++; end
            end
            if (dw) begin
                if (model_q.size() < DEPTH) model_q.push_back({1'b1, p, da, dd});
                else begin m_ovf = 1'b1; m_drops++; end
            end
            tick();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
